// File: rtl/four_output_demux_pkg.sv
// Shared encodings for the four-channel select paths and the output-slot state.
// Used by both the demux and its mux counterpart.
package four_output_demux_pkg;

    localparam int NUM_CHANNELS = 4;

    typedef enum logic [1:0] {
        SEL_A = 2'b00,
        SEL_B = 2'b01,
        SEL_C = 2'b10,
        SEL_D = 2'b11
    } chan_sel_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/four_output_demux_out_slot.sv
// One-entry output holding slot with a valid/ready drain side.
// A write in the same cycle as a drain replaces the word without a bubble.
module demux_out_slot
    import four_output_demux_pkg::*;
#(
    parameter int INPUT_LENGTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [INPUT_LENGTH-1:0] wr_data,
    input  logic                    rd_ready,
    output logic                    valid,
    output logic [INPUT_LENGTH-1:0] data,
    output logic                    can_accept
);

    slot_state_e             state_q, state_d;
    logic [INPUT_LENGTH-1:0] data_q, data_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        // A capture takes priority: it covers both fill and drain-plus-refill.
        if (wr_en) begin
            state_d = FULL;
            data_d  = wr_data;
        end else if (state_q == FULL && rd_ready) begin
            state_d = EMPTY;
        end
    end

    assign valid      = (state_q == FULL);
    assign data       = data_q;
    assign can_accept = (state_q == EMPTY) || rd_ready;

endmodule

// File: rtl/four_output_demux.sv
// Registered 1-to-4 demultiplexer with per-channel one-entry slots.
// Optional broadcast to all channels when DEMUX_BROADCAST_EN is defined.
module four_output_demux
    import four_output_demux_pkg::*;
#(
    parameter int INPUT_LENGTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [INPUT_LENGTH-1:0] in_data,
    input  logic [1:0]              in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
`ifdef DEMUX_BROADCAST_EN
    input  logic                    in_bcast,
`endif
    output logic [INPUT_LENGTH-1:0] out_a_data,
    output logic [INPUT_LENGTH-1:0] out_b_data,
    output logic [INPUT_LENGTH-1:0] out_c_data,
    output logic [INPUT_LENGTH-1:0] out_d_data,
    output logic                    out_a_valid,
    output logic                    out_b_valid,
    output logic                    out_c_valid,
    output logic                    out_d_valid,
    input  logic                    out_a_ready,
    input  logic                    out_b_ready,
    input  logic                    out_c_ready,
    input  logic                    out_d_ready
);

    logic [NUM_CHANNELS-1:0] sel_onehot;
    logic [NUM_CHANNELS-1:0] wr_target;
    logic [NUM_CHANNELS-1:0] slot_ready;
    logic [NUM_CHANNELS-1:0] slot_valid;
    logic [NUM_CHANNELS-1:0] slot_can_accept;
    logic [INPUT_LENGTH-1:0] slot_data [NUM_CHANNELS];
    logic                    handshake;

    always_comb begin
        sel_onehot = '0;
        case (chan_sel_e'(in_sel))
            SEL_A:   sel_onehot = 4'b0001;
            SEL_B:   sel_onehot = 4'b0010;
            SEL_C:   sel_onehot = 4'b0100;
            SEL_D:   sel_onehot = 4'b1000;
            default: sel_onehot = '0;
        endcase
    end

`ifdef DEMUX_BROADCAST_EN
    // Broadcast needs every slot free (or draining) so no channel drops the word.
    assign in_ready  = in_bcast ? (&slot_can_accept) : slot_can_accept[in_sel];
    assign wr_target = in_bcast ? {NUM_CHANNELS{1'b1}} : sel_onehot;
`else
    assign in_ready  = slot_can_accept[in_sel];
    assign wr_target = sel_onehot;
`endif

    assign handshake  = in_valid && in_ready;
    assign slot_ready = {out_d_ready, out_c_ready, out_b_ready, out_a_ready};

    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_slot
            demux_out_slot #(
                .INPUT_LENGTH(INPUT_LENGTH)
            ) u_slot (
                .clk        (clk),
                .rst        (rst),
                .wr_en      (handshake && wr_target[gi]),
                .wr_data    (in_data),
                .rd_ready   (slot_ready[gi]),
                .valid      (slot_valid[gi]),
                .data       (slot_data[gi]),
                .can_accept (slot_can_accept[gi])
            );
        end
    endgenerate

    assign out_a_valid = slot_valid[0];
    assign out_b_valid = slot_valid[1];
    assign out_c_valid = slot_valid[2];
    assign out_d_valid = slot_valid[3];
    assign out_a_data  = slot_data[0];
    assign out_b_data  = slot_data[1];
    assign out_c_data  = slot_data[2];
    assign out_d_data  = slot_data[3];

endmodule

// File: tb/tb_four_output_demux.sv
// Scoreboard testbench for four_output_demux: stimulus pushes expected words
// per channel, a monitor pops and compares on every output transfer.
module tb_four_output_demux;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic        bcast;
    logic [3:0]  out_ready;
    logic [31:0] out_a_data, out_b_data, out_c_data, out_d_data;
    logic        out_a_valid, out_b_valid, out_c_valid, out_d_valid;
    logic [3:0]  out_valid;
    logic [31:0] out_data [4];

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [4][$];

    always #5 clk = ~clk;

    four_output_demux #(.INPUT_LENGTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_sel      (in_sel),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
`ifdef DEMUX_BROADCAST_EN
        .in_bcast    (bcast),
`endif
        .out_a_data  (out_a_data),
        .out_b_data  (out_b_data),
        .out_c_data  (out_c_data),
        .out_d_data  (out_d_data),
        .out_a_valid (out_a_valid),
        .out_b_valid (out_b_valid),
        .out_c_valid (out_c_valid),
        .out_d_valid (out_d_valid),
        .out_a_ready (out_ready[0]),
        .out_b_ready (out_ready[1]),
        .out_c_ready (out_ready[2]),
        .out_d_ready (out_ready[3])
    );

    assign out_valid   = {out_d_valid, out_c_valid, out_b_valid, out_a_valid};
    assign out_data[0] = out_a_data;
    assign out_data[1] = out_b_data;
    assign out_data[2] = out_c_data;
    assign out_data[3] = out_d_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every valid&&ready transfer must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (out_valid[ch] && out_ready[ch]) begin
                    checks++;
                    if (exp_q[ch].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_out ch%0d: got %h expected none", ch, out_data[ch]);
                    end else begin
                        logic [31:0] e;
                        e = exp_q[ch].pop_front();
                        if (out_data[ch] !== e) begin
                            errors++;
                            $display("FAIL out_data ch%0d: got %h expected %h", ch, out_data[ch], e);
                        end else begin
                            $display("out  ch%0d data=%h", ch, out_data[ch]);
                        end
                    end
                end
            end
        end
    end

    // One cycle of stimulus; in_ready is checked mid-cycle against exp_rdy.
    task automatic step(input bit v, input logic [1:0] s, input logic [31:0] d,
                        input logic [3:0] rdy, input bit exp_rdy);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = rdy;
        @(negedge clk);
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
        if (v && exp_rdy) begin
            if (bcast) begin
                for (int k = 0; k < 4; k++) exp_q[k].push_back(d);
            end else begin
                exp_q[s].push_back(d);
            end
        end
        $display("in   valid=%0d sel=%0d bcast=%0d data=%h rdy=%b in_ready=%0d",
                 v, s, bcast, d, rdy, in_ready);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string name);
        chk({name, "_valid"}, {28'b0, out_valid}, 32'h0);
        for (int k = 0; k < 4; k++) chk({name, "_data"}, out_data[k], 32'h0);
        chk({name, "_in_ready"}, {31'b0, in_ready}, 32'h1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sel = 2'b00; in_data = '0;
        out_ready = 4'b0; bcast = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_reset_state("reset");

        // Single word to channel c
        step(1, 2'b10, 32'hDEADBEEF, 4'b0000, 1);
        chk("single_valid", {28'b0, out_valid}, 32'h4);
        chk("single_data", out_c_data, 32'hDEADBEEF);
        step(0, 2'b10, 32'h0, 4'b0100, 1);
        chk("single_drained", {28'b0, out_valid}, 32'h0);

        // Back-pressure isolation: b stalled, d still flows
        step(1, 2'b01, 32'hB0000001, 4'b0000, 1);
        step(1, 2'b01, 32'hB0000002, 4'b0000, 0);
        chk("bp_b_hold", out_b_data, 32'hB0000001);
        step(1, 2'b11, 32'hD0000001, 4'b0000, 1);
        chk("bp_valid", {28'b0, out_valid}, 32'hA);
        chk("bp_b_still", out_b_data, 32'hB0000001);
        step(0, 2'b00, 32'h0, 4'b1010, 1);
        chk("bp_drained", {28'b0, out_valid}, 32'h0);

        // Same-cycle drain and refill on channel a
        step(1, 2'b00, 32'h1, 4'b0000, 1);
        step(1, 2'b00, 32'h2, 4'b0001, 1);
        chk("refill_valid", {28'b0, out_valid}, 32'h1);
        chk("refill_data", out_a_data, 32'h2);
        step(0, 2'b00, 32'h0, 4'b0001, 1);

        // Streaming: one word per cycle cycling through channels
        for (int i = 0; i < 8; i++) begin
            logic [1:0] s;
            s = 2'(i % 4);
            step(1, s, 32'(i), 4'hF, 1);
            chk("stream_valid", {28'b0, out_valid}, 32'(1 << (i % 4)));
            chk("stream_data", out_data[i % 4], 32'(i));
        end
        step(0, 2'b00, 32'h0, 4'hF, 1);
        chk("stream_drained", {28'b0, out_valid}, 32'h0);

        // Mid-operation reset with all slots full and stalled
        for (int i = 0; i < 4; i++) step(1, 2'(i), 32'hF0 + 32'(i), 4'b0000, 1);
        chk("full_valid", {28'b0, out_valid}, 32'hF);
        in_valid = 1'b1; in_sel = 2'b00; in_data = 32'h12345678; rst = 1'b1;
        for (int k = 0; k < 4; k++) exp_q[k].delete();
        @(posedge clk);
        #1 rst = 1'b0; in_valid = 1'b0;
        chk_reset_state("midrst");

`ifdef DEMUX_BROADCAST_EN
        step(1, 2'b10, 32'hCCCC0001, 4'b0000, 1);
        bcast = 1'b1;
        step(1, 2'b00, 32'hA5A5A5A5, 4'b0000, 0);
        step(1, 2'b00, 32'hA5A5A5A5, 4'b0100, 1);
        bcast = 1'b0;
        chk("bcast_valid", {28'b0, out_valid}, 32'hF);
        for (int k = 0; k < 4; k++) chk("bcast_data", out_data[k], 32'hA5A5A5A5);
        step(0, 2'b00, 32'h0, 4'hF, 1);
`endif

        step(0, 2'b00, 32'h0, 4'hF, 1);
        for (int k = 0; k < 4; k++) chk("queue_empty", 32'(exp_q[k].size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
